// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the pixel clock. Issues per-pixel
// fetch requests to a fixed-latency pixel source and realigns the returned RGB
// with delayed hsync/vsync/de so the outputs feed the TMDS stage directly.
// Build macro TEST_PATTERN_EN adds an internal 8-bar colour pattern selected by
// pattern_sel; without it pattern_sel is ignored.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned LATENCY  = 2
) (
  input  logic       clkp,
  input  logic       rst_n,
  output logic       pix_req,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       frame_start,
  input  logic       pattern_sel,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  localparam logic [9:0] HLast   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VLast   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

`ifdef TEST_PATTERN_EN
  // Pipeline word: {bar index x[9:6], hs_on, vs_on, active}
  localparam int unsigned CW = 7;
`else
  // Pipeline word: {hs_on, vs_on, active}
  localparam int unsigned CW = 3;
`endif

  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       active, hs_on, vs_on;
  logic       req_q, fs_q, hs_a_q, vs_a_q;
  logic [9:0] x_q, y_q;
  logic [CW-1:0] a_ctrl, b_ctrl;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Counter next-state and region decode of the current raster position
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == HLast) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 10'd1;
    end
    active = (hcnt_q < HAct) && (vcnt_q < VAct);
    hs_on  = (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
    vs_on  = (vcnt_q >= VsStart) && (vcnt_q < VsEnd);
  end

  // Raster counters and stage A request registers
  always_ff @(posedge clkp) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      req_q  <= 1'b0;
      fs_q   <= 1'b0;
      hs_a_q <= 1'b0;
      vs_a_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      req_q  <= active;
      fs_q   <= (hcnt_q == '0) && (vcnt_q == '0);
      hs_a_q <= hs_on;
      vs_a_q <= vs_on;
      x_q    <= active ? hcnt_q : '0;
      y_q    <= active ? vcnt_q : '0;
    end
  end

  assign pix_req     = req_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;

`ifdef TEST_PATTERN_EN
  assign a_ctrl = {x_q[9:6], hs_a_q, vs_a_q, req_q};
`else
  assign a_ctrl = {hs_a_q, vs_a_q, req_q};
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  // Delay line matching the pixel-source read latency
  if (LATENCY > 0) begin : g_dly
    logic [CW-1:0] sr_q [LATENCY];

    // Shift controls along; reset clears stale slots so no partial line escapes
    always_ff @(posedge clkp) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(LATENCY); i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= a_ctrl;
        for (int i = 1; i < int'(LATENCY); i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign b_ctrl = sr_q[LATENCY-1];
  end else begin : g_nodly
    assign b_ctrl = a_ctrl;
  end

  // Stage B: encode syncs, gate colour with de
  always_comb begin
    de_d    = b_ctrl[0];
    vsync_d = b_ctrl[1] ? SYNC_POL : ~SYNC_POL;
    hsync_d = b_ctrl[2] ? SYNC_POL : ~SYNC_POL;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (de_d) begin
`ifdef TEST_PATTERN_EN
      if (pattern_sel) begin
        case (b_ctrl[6:3])
          4'd0:    {r_d, g_d, b_d} = 24'hFFFFFF;
          4'd1:    {r_d, g_d, b_d} = 24'hFFFF00;
          4'd2:    {r_d, g_d, b_d} = 24'h00FFFF;
          4'd3:    {r_d, g_d, b_d} = 24'h00FF00;
          4'd4:    {r_d, g_d, b_d} = 24'hFF00FF;
          4'd5:    {r_d, g_d, b_d} = 24'hFF0000;
          4'd6:    {r_d, g_d, b_d} = 24'h0000FF;
          default: {r_d, g_d, b_d} = 24'h000000;
        endcase
      end else begin
        r_d = pix_r;
        g_d = pix_g;
        b_d = pix_b;
      end
`else
      r_d = pix_r;
      g_d = pix_g;
      b_d = pix_b;
`endif
    end
  end

  // Stage B output registers
  always_ff @(posedge clkp) begin
    if (!rst_n) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 800-clock lines with a short 9-line frame so
// whole frames fit in a short run. A pixel source returns data derived from the
// requested coordinates LATENCY clocks later; expected outputs are queued when
// each request appears and compared when they are due at the outputs.
module tb_vga_timing_gen;

  localparam int HT  = 800;
  localparam int VT  = 9;
  localparam int HA  = 640;
  localparam int VA  = 4;
  localparam int HS0 = 656;
  localparam int HS1 = 752;
  localparam int VS0 = 5;
  localparam int VS1 = 7;
  localparam int LAT = 2;
  localparam logic [26:0] Idle = {1'b1, 1'b1, 1'b0, 24'h0};

  logic       clkp = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_req, frame_start, pattern_sel;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_r, pix_g, pix_b;
  logic       hsync, vsync, de;
  logic [7:0] r, g, b;

  always #5 clkp = ~clkp;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0), .LATENCY(2)
  ) dut (
    .clkp(clkp), .rst_n(rst_n), .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .frame_start(frame_start),
    .pattern_sel(pattern_sel), .hsync(hsync), .vsync(vsync), .de(de),
    .r(r), .g(g), .b(b)
  );

  typedef struct {
    int         k;
    logic       req;
    logic       fs;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t        tbl[11];
  logic [26:0] sb_q[$];
  logic [9:0]  hx[LAT+1];
  logic [9:0]  hy[LAT+1];
  logic        hv[LAT+1];
  int n_tests = 0;
  int n_fail  = 0;
  int ti = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;
  bit phase1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_restart();
    sb_q.delete();
    for (int i = 0; i <= LAT; i++) begin
      sb_q.push_back(Idle);
      hv[i] = 1'b0;
      hx[i] = '0;
      hy[i] = '0;
    end
  endtask

  // One clock after release-relative edge k: check, score, and drive the source
  task automatic step(input int k);
    int c, h, v;
    logic act, hs, vs;
    logic [7:0] hb, vb;
    logic [26:0] exp_b;
    @(posedge clkp);
    #1;
    c   = (k - 1) % (HT * VT);
    h   = c % HT;
    v   = c / HT;
    act = (h < HA) && (v < VA);
    hs  = (h >= HS0) && (h < HS1);
    vs  = (v >= VS0) && (v < VS1);
    hb  = 8'(h);
    vb  = 8'(v);
    check($sformatf("stage_a k=%0d", k), {pix_req, frame_start, pix_x, pix_y},
          {act, (h == 0 && v == 0), act ? 10'(h) : 10'd0, act ? 10'(v) : 10'd0});
    if (ti < 11 && tbl[ti].k == k) begin
      check($sformatf("vec%0d k=%0d", ti, k), {pix_req, frame_start, pix_x, pix_y},
            {tbl[ti].req, tbl[ti].fs, tbl[ti].x, tbl[ti].y});
      ti++;
    end
    exp_b = sb_q.pop_front();
    check($sformatf("stage_b k=%0d", k), {hsync, vsync, de, r, g, b}, exp_b);
    sb_q.push_back({~hs, ~vs, act, act ? hb : 8'h0, act ? ~hb : 8'h0, act ? vb : 8'h0});
    if (phase1) begin
      if (k >= LAT + 2 && k < LAT + 2 + HT * VT) begin
        de_cnt += int'(de);
        hs_cnt += int'(!hsync);
        vs_cnt += int'(!vsync);
      end
      fs_cnt += int'(frame_start);
    end
    for (int i = LAT; i > 0; i--) begin
      hx[i] = hx[i-1];
      hy[i] = hy[i-1];
      hv[i] = hv[i-1];
    end
    hx[0] = pix_x;
    hy[0] = pix_y;
    hv[0] = pix_req;
    if (hv[LAT]) begin
      pix_r = hx[LAT][7:0];
      pix_g = ~hx[LAT][7:0];
      pix_b = hy[LAT][7:0];
    end else begin
      pix_r = 8'($urandom);
      pix_g = 8'($urandom);
      pix_b = 8'($urandom);
    end
    pattern_sel = 1'($urandom);
  endtask

  initial begin
    tbl[0]  = '{k: 1,    req: 1'b1, fs: 1'b1, x: 10'd0,   y: 10'd0};
    tbl[1]  = '{k: 2,    req: 1'b1, fs: 1'b0, x: 10'd1,   y: 10'd0};
    tbl[2]  = '{k: 640,  req: 1'b1, fs: 1'b0, x: 10'd639, y: 10'd0};
    tbl[3]  = '{k: 641,  req: 1'b0, fs: 1'b0, x: 10'd0,   y: 10'd0};
    tbl[4]  = '{k: 801,  req: 1'b1, fs: 1'b0, x: 10'd0,   y: 10'd1};
    tbl[5]  = '{k: 3040, req: 1'b1, fs: 1'b0, x: 10'd639, y: 10'd3};
    tbl[6]  = '{k: 3200, req: 1'b0, fs: 1'b0, x: 10'd0,   y: 10'd0};
    tbl[7]  = '{k: 3201, req: 1'b0, fs: 1'b0, x: 10'd0,   y: 10'd0};
    tbl[8]  = '{k: 7200, req: 1'b0, fs: 1'b0, x: 10'd0,   y: 10'd0};
    tbl[9]  = '{k: 7201, req: 1'b1, fs: 1'b1, x: 10'd0,   y: 10'd0};
    tbl[10] = '{k: 7202, req: 1'b1, fs: 1'b0, x: 10'd1,   y: 10'd0};

    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    pattern_sel = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clkp);
    #1;
    check("reset_out", {hsync, vsync, de, r, g, b}, Idle);
    check("reset_req", {pix_req, frame_start, pix_x, pix_y}, 64'd0);

    rst_n = 1'b1;
    sb_restart();
    phase1 = 1'b1;
    for (int k = 1; k <= HT * VT + 1900; k++) step(k);
    phase1 = 1'b0;
    check("de_clocks_per_frame", de_cnt, HA * VA);
    check("hsync_low_clocks", hs_cnt, (HS1 - HS0) * VT);
    check("vsync_low_clocks", vs_cnt, (VS1 - VS0) * HT);
    check("frame_start_count", fs_cnt, 2);

    // Counters now sit at hcnt=300, vcnt=2: reset mid-line for 3 clocks
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clkp);
      #1;
      check($sformatf("midrst_out %0d", i), {hsync, vsync, de, r, g, b}, Idle);
      check($sformatf("midrst_req %0d", i), {pix_req, frame_start, pix_x, pix_y}, 64'd0);
    end
    rst_n = 1'b1;
    sb_restart();
    for (int k = 1; k <= 1700; k++) step(k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
